// File: rtl/base_arfilter_mc_pkg.sv
// Shared types for the multi-channel valid/ready filter.
package base_arfilter_pkg;

    localparam int MODE_W = 2;

    // Per-channel operating mode.
    typedef enum logic [MODE_W-1:0] {
        PASS  = 2'd0,
        HOLD  = 2'd1,
        DROP  = 2'd2,
        METER = 2'd3
    } mode_t;

endpackage

// File: rtl/base_arfilter_mc_if.sv
// Per-channel valid/ready handshake bundle. The master side is the
// producer/consumer pair around the filter; the slave side is the filter.
interface base_arfilter_mc_if #(
    parameter int n = 4
) ();
    logic [n-1:0] i_v;
    logic [n-1:0] i_r;
    logic [n-1:0] o_v;
    logic [n-1:0] o_r;

    modport master (output i_v, output o_r, input i_r, input o_v);
    modport slave  (input i_v, input o_r, output i_r, output o_v);
endinterface

// File: rtl/base_arfilter_mc_ch.sv
// One filter channel: applied mode, pending mode, credit meter and
// saturating drop counter. Handshake path is purely combinational.
module base_arfilter_ch
    import base_arfilter_pkg::*;
#(
    parameter int cw = 8,
    parameter int dw = 16
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          mode_ld,
    input  mode_t         mode_d,
    input  logic          cred_ld,
    input  logic [cw-1:0] cred_d,
    input  logic          cnt_clr,
    input  logic          i_v,
    output logic          i_r,
    output logic          o_v,
    input  logic          o_r,
    output mode_t         mode_q,
    output logic [cw-1:0] cred_q,
    output logic [dw-1:0] drop_q
);

    mode_t         mode_r, mode_nx;
    mode_t         pend_m, pend_m_nx;
    logic          pend_v, pend_v_nx;
    mode_t         eff;
    logic [cw-1:0] cred_r;
    logic [dw-1:0] drop_r;
    logic          stall, fire;

    // METER folds into PASS or HOLD depending on remaining credit; then the
    // effective mode decides the handshake.
    always_comb begin
        eff = mode_r;
        if (mode_r == METER) eff = (cred_r != '0) ? PASS : HOLD;
        o_v = i_v;
        i_r = o_r;
        case (eff)
            HOLD:    i_r = 1'b0;
            DROP:    begin o_v = 1'b0; i_r = 1'b1; end
            default: ;
        endcase
    end

    assign stall = o_v & ~o_r;
    assign fire  = o_v & o_r;

    // Next mode: a strobe always lands in the pending slot (last wins), and
    // the pending value is only committed on an edge with no stalled beat.
    always_comb begin
        mode_nx   = mode_r;
        pend_m_nx = pend_m;
        pend_v_nx = pend_v;
        if (mode_ld) begin
            pend_m_nx = mode_d;
            pend_v_nx = 1'b1;
        end
        if (pend_v_nx && !stall) begin
            mode_nx   = pend_m_nx;
            pend_v_nx = 1'b0;
        end
    end

    // Mode and pending registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mode_r <= PASS;
            pend_m <= PASS;
            pend_v <= 1'b0;
        end else begin
            mode_r <= mode_nx;
            pend_m <= pend_m_nx;
            pend_v <= pend_v_nx;
        end
    end

    // Credit: load beats decrement; only METER consumes, never below zero.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            cred_r <= '0;
        else if (cred_ld)
            cred_r <= cred_d;
        else if (mode_r == METER && fire && cred_r != '0)
            cred_r <= cred_r - 1'b1;
    end

    // Drop counter: counts discarded beats, saturates, clear has priority.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            drop_r <= '0;
        else if (cnt_clr)
            drop_r <= '0;
        else if (eff == DROP && i_v && i_r && drop_r != '1)
            drop_r <= drop_r + 1'b1;
    end

    assign mode_q = mode_r;
    assign cred_q = cred_r;
    assign drop_q = drop_r;

endmodule

// File: rtl/base_arfilter_mc.sv
// Multi-channel valid/ready filter top: n independent channels, status
// buses packed with channel c occupying the c-th field from bit 0 upward.
module base_arfilter_mc
    import base_arfilter_pkg::*;
#(
    parameter int n  = 4,
    parameter int cw = 8,
    parameter int dw = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [n-1:0]      mode_ld,
    input  logic [1:0]        mode_d,
    input  logic [n-1:0]      cred_ld,
    input  logic [cw-1:0]     cred_d,
    input  logic [n-1:0]      cnt_clr,
    base_arfilter_mc_if.slave bus,
    output logic [2*n-1:0]    mode_q,
    output logic [n*cw-1:0]   cred_q,
    output logic [n*dw-1:0]   drop_q
);

    logic [n-1:0] ir_w;
    logic [n-1:0] ov_w;

    for (genvar c = 0; c < n; c++) begin : g_ch
        mode_t         m;
        logic [cw-1:0] cq;
        logic [dw-1:0] dq;

        base_arfilter_ch #(.cw(cw), .dw(dw)) u_ch (
            .clk     (clk),
            .reset_n (reset_n),
            .mode_ld (mode_ld[c]),
            .mode_d  (mode_t'(mode_d)),
            .cred_ld (cred_ld[c]),
            .cred_d  (cred_d),
            .cnt_clr (cnt_clr[c]),
            .i_v     (bus.i_v[c]),
            .i_r     (ir_w[c]),
            .o_v     (ov_w[c]),
            .o_r     (bus.o_r[c]),
            .mode_q  (m),
            .cred_q  (cq),
            .drop_q  (dq)
        );

        assign mode_q[2*c +: 2]   = m;
        assign cred_q[c*cw +: cw] = cq;
        assign drop_q[c*dw +: dw] = dq;
    end

    assign bus.i_r = ir_w;
    assign bus.o_v = ov_w;

endmodule

// File: tb/tb_base_arfilter_mc.sv
// Self-checking bench for base_arfilter_mc (n=2, cw=8, dw=3).
// Each step pushes its expected observation; the step's sample pops it.
module tb_base_arfilter_mc;
    import base_arfilter_pkg::*;

    localparam int N  = 2;
    localparam int CW = 8;
    localparam int DW = 3;

    logic            clk = 1'b0;
    logic            reset_n;
    logic [N-1:0]    mode_ld, cred_ld, cnt_clr;
    logic [1:0]      mode_d;
    logic [CW-1:0]   cred_d;
    logic [2*N-1:0]  mode_q;
    logic [N*CW-1:0] cred_q;
    logic [N*DW-1:0] drop_q;

    base_arfilter_mc_if #(.n(N)) bus ();

    base_arfilter_mc #(.n(N), .cw(CW), .dw(DW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .mode_ld (mode_ld),
        .mode_d  (mode_d),
        .cred_ld (cred_ld),
        .cred_d  (cred_d),
        .cnt_clr (cnt_clr),
        .bus     (bus),
        .mode_q  (mode_q),
        .cred_q  (cred_q),
        .drop_q  (drop_q)
    );

    always #5 clk = ~clk;

    // {i_r, o_v} sampled before the edge, status sampled after it.
    typedef struct packed {
        logic          ir;
        logic          ov;
        logic [1:0]    mode;
        logic [CW-1:0] cred;
        logic [DW-1:0] drop;
    } exp_t;

    exp_t          sb[$];
    int            vectors = 0;
    int            errors  = 0;
    logic [N-1:0]  c_ir, c_ov;
    logic [1:0]    r_mode[N];
    logic [CW-1:0] r_cred[N];
    logic [DW-1:0] r_drop[N];

    function automatic exp_t mk(logic ir, logic ov, int m, int cr, int dr);
        mk = {ir, ov, m[1:0], cr[CW-1:0], dr[DW-1:0]};
    endfunction

    function automatic exp_t obs(int c);
        obs = {c_ir[c], c_ov[c], r_mode[c], r_cred[c], r_drop[c]};
    endfunction

    task automatic sample_comb();
        c_ir = bus.i_r;
        c_ov = bus.o_v;
    endtask

    task automatic sample_regs();
        for (int c = 0; c < N; c++) begin
            r_mode[c] = mode_q[2*c +: 2];
            r_cred[c] = cred_q[c*CW +: CW];
            r_drop[c] = drop_q[c*DW +: DW];
        end
    endtask

    // s = {i_v, o_r, mode_ld, cred_ld, cnt_clr} for one channel
    task automatic drive(int c, logic [4:0] s);
        bus.i_v[c] = s[4];
        bus.o_r[c] = s[3];
        mode_ld[c] = s[2];
        cred_ld[c] = s[1];
        cnt_clr[c] = s[0];
    endtask

    task automatic cycle();
        #2;
        sample_comb();
        @(posedge clk);
        #1;
        sample_regs();
    endtask

    task automatic test_reset();
        logic [4:0] st[4];
        exp_t ex[4];
        exp_t e, o;
        st = '{5'b10000, 5'b11000, 5'b10000, 5'b11000};
        ex = '{mk(0,1,0,0,0), mk(1,1,0,0,0), mk(0,1,0,0,0), mk(1,1,0,0,0)};
        for (int k = 0; k < 4; k++) begin
            if (k == 2) reset_n = 1'b1;
            drive(0, st[k]);
            sb.push_back(ex[k]);
            cycle();
            e = sb.pop_front();
            o = obs(0);
            vectors++;
            if (o !== e) begin
                errors++;
                $display("FAIL reset step %0d: got %h want %h", k, o, e);
            end
        end
    endtask

    task automatic test_meter();
        logic [4:0] st[6];
        exp_t ex[6];
        exp_t e, o;
        int fires = 0;
        mode_d = METER;
        cred_d = 8'd3;
        st = '{5'b01110, 5'b11000, 5'b11000, 5'b11000, 5'b11000, 5'b11000};
        ex = '{mk(1,0,3,3,0), mk(1,1,3,2,0), mk(1,1,3,1,0),
               mk(1,1,3,0,0), mk(0,1,3,0,0), mk(0,1,3,0,0)};
        for (int k = 0; k < 6; k++) begin
            drive(0, st[k]);
            sb.push_back(ex[k]);
            cycle();
            if (c_ir[0] && c_ov[0] && st[k][4] && st[k][3]) fires++;
            e = sb.pop_front();
            o = obs(0);
            vectors++;
            if (o !== e) begin
                errors++;
                $display("FAIL meter step %0d: got %h want %h", k, o, e);
            end
        end
        vectors++;
        if (fires !== 3) begin
            errors++;
            $display("FAIL meter fire count: got %0d want 3", fires);
        end
    endtask

    task automatic test_cred_load();
        logic [4:0] st[4];
        int cd[4];
        exp_t ex[4];
        exp_t e, o;
        st = '{5'b11010, 5'b11010, 5'b11000, 5'b00000};
        cd = '{1, 5, 0, 0};
        ex = '{mk(0,1,3,1,0), mk(1,1,3,5,0), mk(1,1,3,4,0), mk(0,0,3,4,0)};
        for (int k = 0; k < 4; k++) begin
            cred_d = cd[k][CW-1:0];
            drive(0, st[k]);
            sb.push_back(ex[k]);
            cycle();
            e = sb.pop_front();
            o = obs(0);
            vectors++;
            if (o !== e) begin
                errors++;
                $display("FAIL cred_load step %0d: got %h want %h", k, o, e);
            end
        end
    endtask

    task automatic test_drop();
        logic [4:0] st[13];
        exp_t ex[13];
        exp_t e, o;
        mode_d = DROP;
        st[0] = 5'b00100;
        ex[0] = mk(0,0,2,0,0);
        for (int k = 1; k <= 9; k++) begin
            st[k] = 5'b10000;
            ex[k] = mk(1,0,2,0,(k > 7) ? 7 : k);
        end
        st[10] = 5'b10001; ex[10] = mk(1,0,2,0,0);
        st[11] = 5'b10000; ex[11] = mk(1,0,2,0,1);
        st[12] = 5'b00000; ex[12] = mk(1,0,2,0,1);
        for (int k = 0; k < 13; k++) begin
            drive(1, st[k]);
            sb.push_back(ex[k]);
            cycle();
            e = sb.pop_front();
            o = obs(1);
            vectors++;
            if (o !== e) begin
                errors++;
                $display("FAIL drop step %0d: got %h want %h", k, o, e);
            end
        end
        // ch0 was idle throughout and must keep its credit
        o = obs(0);
        vectors++;
        if (o !== mk(0,0,3,4,0)) begin
            errors++;
            $display("FAIL drop ch0 independence: got %h want %h", o, mk(0,0,3,4,0));
        end
    endtask

    task automatic test_stall_mode();
        logic [4:0] st[6];
        logic [1:0] md[6];
        exp_t ex[6];
        exp_t e, o;
        st = '{5'b00100, 5'b10100, 5'b10100, 5'b10000, 5'b11000, 5'b11000};
        md = '{PASS, HOLD, DROP, PASS, PASS, PASS};
        ex = '{mk(0,0,0,4,0), mk(0,1,0,4,0), mk(0,1,0,4,0),
               mk(0,1,0,4,0), mk(1,1,2,4,0), mk(1,0,2,4,1)};
        for (int k = 0; k < 6; k++) begin
            mode_d = md[k];
            drive(0, st[k]);
            sb.push_back(ex[k]);
            cycle();
            e = sb.pop_front();
            o = obs(0);
            vectors++;
            if (o !== e) begin
                errors++;
                $display("FAIL stall_mode step %0d: got %h want %h", k, o, e);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [4:0] st[4];
        exp_t ex[4];
        exp_t e, o;
        st = '{5'b00110, 5'b10100, 5'b11000, 5'b10000};
        ex = '{mk(1,0,3,2,1), mk(0,1,3,2,1), mk(1,1,0,0,0), mk(0,1,0,0,0)};
        cred_d = 8'd2;
        for (int k = 0; k < 4; k++) begin
            mode_d = (k == 0) ? METER : HOLD;
            if (k == 2) begin
                // stalled in METER with a pending HOLD: pull reset mid-cycle
                drive(0, 5'b10000);
                reset_n = 1'b0;
                sb.push_back(mk(0,1,0,0,0));
                #2;
                sample_comb();
                sample_regs();
                e = sb.pop_front();
                o = obs(0);
                vectors++;
                if (o !== e) begin
                    errors++;
                    $display("FAIL reset_mid in reset: got %h want %h", o, e);
                end
                o = obs(1);
                vectors++;
                if (o !== mk(0,0,0,0,0)) begin
                    errors++;
                    $display("FAIL reset_mid ch1 cleared: got %h want %h", o, mk(0,0,0,0,0));
                end
                reset_n = 1'b1;
            end
            drive(0, st[k]);
            sb.push_back(ex[k]);
            cycle();
            e = sb.pop_front();
            o = obs(0);
            vectors++;
            if (o !== e) begin
                errors++;
                $display("FAIL reset_mid step %0d: got %h want %h", k, o, e);
            end
        end
    endtask

    initial begin
        reset_n = 1'b0;
        mode_ld = '0;
        cred_ld = '0;
        cnt_clr = '0;
        mode_d  = '0;
        cred_d  = '0;
        bus.i_v = '0;
        bus.o_r = '0;
        test_reset();
        drive(0, 5'b00000);
        test_meter();
        test_cred_load();
        test_drop();
        test_stall_mode();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/base_arfilter_mc.md
# base_arfilter_mc

Multi-channel valid/ready filter with registered per-channel modes, credit metering and a saturating drop counter. Each channel sits between a producer and consumer with zero-latency combinational pass-through. A control agent programs each channel at run time to pass, hold, drop, or meter a bounded number of beats. Mode changes never break a stalled beat.

## Interface
- `n`, 4: channel count.
- `cw`, 8: credit counter width.
- `dw`, 16: drop counter width.
- `clk`  in  1  clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `mode_ld`  in  [0:n-1]  per-channel mode load strobe.
- `mode_d`  in  [0:1]  mode value, shared by all strobed channels.
- `cred_ld`  in  [0:n-1]  per-channel credit load strobe.
- `cred_d`  in  [0:cw-1]  credit value, shared.
- `cnt_clr`  in  [0:n-1]  per-channel drop counter clear.
- `i_v`  in  [0:n-1]  input valid.
- `i_r`  out  [0:n-1]  input ready.
- `o_v`  out  [0:n-1]  output valid.
- `o_r`  in  [0:n-1]  output ready.
- `mode_q`  out  [0:2n-1]  applied mode, channel c at bits [2c:2c+1].
- `cred_q`  out  [0:n*cw-1]  credit remaining, channel c at [c*cw:(c+1)*cw-1].
- `drop_q`  out  [0:n*dw-1]  drop count, same packing.

## Operation
Modes:
- PASS=0: o_v=i_v, i_r=o_r.
- HOLD=1: o_v=i_v, i_r=0. The beat is presented repeatedly and never consumed.
- DROP=2: o_v=0, i_r=1. Every input beat is discarded.
- METER=3:
  - cred>0: behaves as PASS, and cred decrements by 1 on each fire (o_v&o_r).
  - cred==0: behaves as HOLD.

Mode loading:
- `stall` = o_v & ~o_r.
- `mode_ld` writes a pending-mode register and sets a pending flag.
- The pending mode is applied at a clock edge where stall=0.
- A further `mode_ld` while pending overwrites the pending value (last wins).
- `mode_ld` in a cycle where stall=0 applies at that same edge.

Credit:
- `cred_ld` loads `cred_d`. When load and fire occur in the same cycle, load wins and no decrement happens.
- Credit never underflows.
- Credit is held in non-METER modes.

Drop counter:
- Increments on each i_v&i_r cycle in DROP mode.
- Saturates at 2^dw-1.
- `cnt_clr` wins over a simultaneous increment; the result is 0.

Reset (reset_n low, asynchronous):
- mode_q=PASS, pending cleared, cred_q=0, drop_q=0.
- During reset, o_v=i_v and i_r=o_r (PASS behaviour).

## Timing
- i_r and o_v are combinational from i_v, o_r and registered state. Data latency through the block is 0 cycles.
- mode_q, cred_q and drop_q update on the edge following their cause.
- A loaded mode affects i_r/o_v no earlier than 1 cycle after `mode_ld`.
- METER with cred=1: the beat that fires takes cred to 0. The next cycle the channel presents as HOLD.
- Credit loaded while METER holds at 0 opens the channel the cycle after the load.
- Reset asserted mid-stall: state clears immediately. No handshake guarantee holds across reset.
- Channels are fully independent. No cross-channel arbitration.

## Structure
- Package `base_arfilter_pkg`: 2-bit mode typedef with PASS/HOLD/DROP/METER constants.
- Sub-module `base_arfilter_ch` holds one channel's state and logic: mode, pending mode, credit, drop counter.
- Top level generates n instances and packs the status buses.

## Test plan
- n=2, reset, ch0 PASS, i_v=1 and o_r toggling → i_r mirrors o_r; mode_q=0; cred_q=0; drop_q=0.
- ch0 METER, cred_ld with cred_d=3, continuous i_v/o_r → exactly 3 fires, cred_q 3→2→1→0, then i_r=0 with o_v=1 held.
- ch1 DROP, i_v=1 for 5 cycles → o_v=0, i_r=1, drop_q=5. With dw=3, after 9 drops drop_q stays at 7. `cnt_clr` with a simultaneous drop → 0.
- ch0 PASS with o_r=0 (stalled) and `mode_ld` DROP → mode_q stays PASS and o_v stays 1 until o_r=1 fires. DROP applies at the next edge.
- METER with cred=1 and fire coinciding with `cred_ld` of 5 → cred_q=5, not 4.
- Assert reset_n low while ch0 METER with cred=2 and pending mode set → next observed: mode_q=PASS, cred_q=0, pending cleared. Release reset → PASS behaviour.
